// File: rtl/hs_drv_pkg.sv
// Shared types and helpers for the handshake multi-run driver.
//   state_e       : driver FSM states
//   LFSR_TAPS     : feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   lfsr_next()   : one LFSR step
//   lfsr_fix_seed : maps the all-zero lock-up seed to 16'h0001
package hs_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bits 15,13,12,10 correspond to taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

  function automatic logic [15:0] lfsr_fix_seed(input logic [15:0] s);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/hs_lfsr16.sv
// 16-bit Fibonacci LFSR used to gate result/control readiness.
// Ports:
//   clock      : rising-edge clock
//   reset      : asynchronous active-low reset, loads RESET_SEED
//   en         : advance one step this cycle
//   load       : reload seed (has priority over en)
//   seed [15:0]: value loaded on load
//   q    [15:0]: current LFSR state
module hs_lfsr16
  import hs_drv_pkg::*;
#(
  parameter logic [15:0] RESET_SEED = 16'h0001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= RESET_SEED;
    end else if (load) begin
      q <= seed;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/hs_multi_run_driver.sv
// Stimulus/response engine for handshake-lowered DUTs. Drives NUM_ARGS
// valid/ready argument channels, collects one result and one control token
// per run, repeats for num_runs runs and accumulates the results. A watchdog
// aborts the sequence when no handshake occurs for TIMEOUT busy cycles.
// Ports:
//   clock, reset          : clock, async active-low reset
//   start                 : launch pulse, honoured only in IDLE/DONE
//   num_runs, arg_seed    : run count and per-channel base values, latched on start
//   arg_valid/ready/data  : argument channels, data = seed[k] + run_idx
//   res_valid/ready/data  : result channel
//   ctrl_valid/ready      : control-token channel
//   busy, done, timed_out : status
//   run_idx               : completed runs
//   last_result, result_sum : last captured result and wrapping sum
//
// state | meaning
// IDLE  | after reset, waiting for start
// ISSUE | presenting arguments not yet accepted this run
// WAIT  | all arguments accepted, waiting for result and control token
// DONE  | sequence finished or aborted; status held until next start
module hs_multi_run_driver
  import hs_drv_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          NUM_ARGS  = 2,
  parameter int          BP_MODE   = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          TIMEOUT   = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [7:0]                 num_runs,
  input  logic [NUM_ARGS*DATA_W-1:0] arg_seed,
  output logic [NUM_ARGS-1:0]        arg_valid,
  input  logic [NUM_ARGS-1:0]        arg_ready,
  output logic [NUM_ARGS*DATA_W-1:0] arg_data,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [DATA_W-1:0]          res_data,
  input  logic                       ctrl_valid,
  output logic                       ctrl_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       timed_out,
  output logic [7:0]                 run_idx,
  output logic [DATA_W-1:0]          last_result,
  output logic [DATA_W-1:0]          result_sum
);

  localparam int          WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [15:0] SEED_EFF = lfsr_fix_seed(LFSR_SEED);

  state_e                     state, state_nxt;
  logic [NUM_ARGS-1:0]        acc_q;
  logic [NUM_ARGS-1:0]        arg_hs;
  logic [NUM_ARGS-1:0]        acc_all;
  logic                       res_got, ctrl_got;
  logic [7:0]                 num_runs_q;
  logic [NUM_ARGS*DATA_W-1:0] seed_q;
  logic [WD_W-1:0]            wd_cnt;
  logic [15:0]                lfsr_q;
  logic                       lfsr_unused;
  logic                       start_ok;
  logic                       wd_expire;
  logic                       res_hs, ctrl_hs, any_hs;
  logic                       run_complete, last_run;
  logic                       bp_res, bp_ctrl;

  assign busy     = (state == ISSUE) || (state == WAIT);
  assign done     = (state == DONE);
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  // The expiry cycle already masks all valids/readys so nothing is accepted
  // on the way into DONE.
  assign wd_expire = busy && (wd_cnt == WD_W'(TIMEOUT));

  assign bp_res  = (BP_MODE != 0) ? lfsr_q[0] : 1'b1;
  assign bp_ctrl = (BP_MODE != 0) ? lfsr_q[1] : 1'b1;

  assign arg_valid  = ((state == ISSUE) && !wd_expire) ? ~acc_q : '0;
  assign res_ready  = busy && !wd_expire && !res_got && bp_res;
  assign ctrl_ready = busy && !wd_expire && !ctrl_got && bp_ctrl;

  assign arg_hs  = arg_valid & arg_ready;
  assign acc_all = acc_q | arg_hs;
  assign res_hs  = res_valid && res_ready;
  assign ctrl_hs = ctrl_valid && ctrl_ready;
  assign any_hs  = (|arg_hs) || res_hs || ctrl_hs;

  // Uses registered flags so WAIT always lasts at least one cycle.
  assign run_complete = (state == WAIT) && (&acc_q) && res_got && ctrl_got;
  assign last_run     = ((run_idx + 8'd1) == num_runs_q);

  for (genvar k = 0; k < NUM_ARGS; k++) begin : g_data
    assign arg_data[k*DATA_W +: DATA_W] = seed_q[k*DATA_W +: DATA_W] + DATA_W'(run_idx);
  end

  hs_lfsr16 #(
    .RESET_SEED(SEED_EFF)
  ) u_lfsr (
    .clock(clock),
    .reset(reset),
    .en   (busy),
    .load (start_ok),
    .seed (SEED_EFF),
    .q    (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[15:2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = (num_runs == 8'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (wd_expire) begin
          state_nxt = DONE;
        end else if (&acc_all) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (wd_expire) begin
          state_nxt = DONE;
        end else if (run_complete) begin
          state_nxt = last_run ? DONE : ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      res_got     <= 1'b0;
      ctrl_got    <= 1'b0;
      num_runs_q  <= '0;
      seed_q      <= '0;
      wd_cnt      <= '0;
      run_idx     <= '0;
      last_result <= '0;
      result_sum  <= '0;
      timed_out   <= 1'b0;
    end else if (start_ok) begin
      acc_q       <= '0;
      res_got     <= 1'b0;
      ctrl_got    <= 1'b0;
      num_runs_q  <= num_runs;
      seed_q      <= arg_seed;
      wd_cnt      <= '0;
      run_idx     <= '0;
      last_result <= '0;
      result_sum  <= '0;
      timed_out   <= 1'b0;
    end else if (busy) begin
      if (wd_expire) begin
        timed_out <= 1'b1;
        acc_q     <= '0;
        res_got   <= 1'b0;
        ctrl_got  <= 1'b0;
        wd_cnt    <= '0;
      end else begin
        if (run_complete) begin
          acc_q    <= '0;
          res_got  <= 1'b0;
          ctrl_got <= 1'b0;
          run_idx  <= run_idx + 8'd1;
        end else begin
          acc_q <= acc_all;
          if (res_hs) begin
            res_got <= 1'b1;
          end
          if (ctrl_hs) begin
            ctrl_got <= 1'b1;
          end
        end
        if (res_hs) begin
          last_result <= res_data;
          result_sum  <= result_sum + res_data;
        end
        wd_cnt <= any_hs ? '0 : wd_cnt + WD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hs_multi_run_driver.sv
// Directed bench for hs_multi_run_driver. Two instances: u[0] with BP_MODE=0
// and TIMEOUT=16, u[1] with BP_MODE=1. Each has an adder responder that sums
// the two arguments of a run and returns the sum plus a control token.
module tb_hs_multi_run_driver;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  always #5 clock = ~clock;

  logic        start      [2];
  logic [7:0]  num_runs   [2];
  logic [63:0] arg_seed   [2];
  logic [1:0]  arg_ready  [2];
  logic        res_en     [2];
  logic        ctrl_first [2];
  logic [1:0]  done_v;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : u
    logic [1:0]  arg_valid;
    logic [63:0] arg_data;
    logic        res_valid, res_ready, ctrl_valid, ctrl_ready;
    logic        busy, done, timed_out;
    logic [31:0] res_data, last_result, result_sum;
    logic [7:0]  run_idx;
    logic [1:0]  got;
    logic [31:0] a0, a1;
    logic        phase, r_left, c_left;
    int          res_cnt, ctrl_cnt;

    assign done_v[g] = done;

    hs_multi_run_driver #(
      .DATA_W   (32),
      .NUM_ARGS (2),
      .BP_MODE  (g),
      .LFSR_SEED(16'hACE1),
      .TIMEOUT  ((g == 0) ? 16 : 1024)
    ) dut (
      .clock      (clock),
      .reset      (rst_n),
      .start      (start[g]),
      .num_runs   (num_runs[g]),
      .arg_seed   (arg_seed[g]),
      .arg_valid  (arg_valid),
      .arg_ready  (arg_ready[g]),
      .arg_data   (arg_data),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .ctrl_valid (ctrl_valid),
      .ctrl_ready (ctrl_ready),
      .busy       (busy),
      .done       (done),
      .timed_out  (timed_out),
      .run_idx    (run_idx),
      .last_result(last_result),
      .result_sum (result_sum)
    );

    // Adder responder: gathers both arguments, then offers result and token.
    always @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        got <= 2'b00; a0 <= '0; a1 <= '0; phase <= 1'b0;
        r_left <= 1'b0; c_left <= 1'b0;
        res_valid <= 1'b0; ctrl_valid <= 1'b0; res_data <= '0;
        res_cnt <= 0; ctrl_cnt <= 0;
      end else if (!phase) begin
        if (got == 2'b11) begin
          if (res_en[g]) begin
            phase      <= 1'b1;
            got        <= 2'b00;
            res_data   <= a0 + a1;
            r_left     <= 1'b1;
            c_left     <= 1'b1;
            ctrl_valid <= 1'b1;
            res_valid  <= !ctrl_first[g];
          end
        end else begin
          if (arg_valid[0] && arg_ready[g][0]) begin got[0] <= 1'b1; a0 <= arg_data[31:0]; end
          if (arg_valid[1] && arg_ready[g][1]) begin got[1] <= 1'b1; a1 <= arg_data[63:32]; end
        end
      end else begin
        if (ctrl_valid && ctrl_ready) begin
          ctrl_valid <= 1'b0;
          c_left     <= 1'b0;
          ctrl_cnt   <= ctrl_cnt + 1;
          if (ctrl_first[g]) res_valid <= 1'b1;
        end
        if (res_valid && res_ready) begin
          res_valid <= 1'b0;
          r_left    <= 1'b0;
          res_cnt   <= res_cnt + 1;
        end
        if ((!r_left || (res_valid && res_ready)) && (!c_left || (ctrl_valid && ctrl_ready)))
          phase <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input int g, input logic [7:0] n, input logic [63:0] seed);
    num_runs[g] = n;
    arg_seed[g] = seed;
    start[g]    = 1'b1;
    tick();
    start[g]    = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (done_v[g]) break;
      tick();
    end
    chk(tag, done_v[g], 1'b1);
  endtask

  initial begin
    int cnt;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0; num_runs[g] = '0; arg_seed[g] = '0;
      arg_ready[g] = 2'b11; res_en[g] = 1'b1; ctrl_first[g] = 1'b0;
    end
    ctrl_first[1] = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_done", u[0].done, 1'b0);
    chk("rst_busy", u[0].busy, 1'b0);
    chk("rst_arg_valid", u[0].arg_valid, 2'b00);
    chk("rst_res_ready", u[0].res_ready, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single run, seeds {5,7}.
    pulse_start(0, 8'd1, {32'd7, 32'd5});
    chk("t1_valid", u[0].arg_valid, 2'b11);
    chk("t1_data", u[0].arg_data, {32'd7, 32'd5});
    wait_done(0, 100, "t1_done");
    chk("t1_last", u[0].last_result, 32'd12);
    chk("t1_sum", u[0].result_sum, 32'd12);
    chk("t1_run_idx", u[0].run_idx, 8'd1);
    chk("t1_busy", u[0].busy, 1'b0);

    // Three runs, seeds {1,2}; a start pulse while busy must be ignored.
    pulse_start(0, 8'd3, {32'd2, 32'd1});
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 50; i++) begin
        if (u[0].arg_valid == 2'b11) break;
        tick();
      end
      chk($sformatf("t2_data_run%0d", r), u[0].arg_data, {32'(2 + r), 32'(1 + r)});
      if (r == 0) begin
        num_runs[0] = 8'd9;
        start[0]    = 1'b1;
        tick();
        start[0]    = 1'b0;
      end else begin
        tick();
      end
    end
    wait_done(0, 100, "t2_done");
    chk("t2_sum", u[0].result_sum, 32'd15);
    chk("t2_run_idx", u[0].run_idx, 8'd3);
    chk("t2_timed_out", u[0].timed_out, 1'b0);

    // Channel 1 stalled for 3 cycles after channel 0 is accepted.
    arg_ready[0] = 2'b01;
    pulse_start(0, 8'd1, {32'd20, 32'd10});
    chk("t3_valid_both", u[0].arg_valid, 2'b11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t3_valid_c%0d", i), u[0].arg_valid, 2'b10);
      chk($sformatf("t3_data1_c%0d", i), u[0].arg_data[63:32], 32'd20);
    end
    arg_ready[0] = 2'b11;
    tick();
    chk("t3_valid_after", u[0].arg_valid, 2'b00);
    chk("t3_busy", u[0].busy, 1'b1);
    wait_done(0, 100, "t3_done");
    chk("t3_last", u[0].last_result, 32'd30);

    // Backpressure instance, token before result, 4 runs, seeds {100,3}.
    pulse_start(1, 8'd4, {32'd3, 32'd100});
    wait_done(1, 3000, "t4_done");
    chk("t4_sum", u[1].result_sum, 32'd424);
    chk("t4_last", u[1].last_result, 32'd109);
    chk("t4_run_idx", u[1].run_idx, 8'd4);
    chk("t4_res_cnt", u[1].res_cnt, 4);
    chk("t4_ctrl_cnt", u[1].ctrl_cnt, 4);
    chk("t4_timed_out", u[1].timed_out, 1'b0);

    // No response at all: watchdog of 16 fires 17 edges after the arg handshake.
    res_en[0] = 1'b0;
    pulse_start(0, 8'd2, {32'd4, 32'd3});
    chk("t5_issue", u[0].arg_valid, 2'b11);
    tick();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (u[0].done) break;
      tick();
      cnt++;
    end
    chk("t5_edges_to_done", cnt, 17);
    chk("t5_timed_out", u[0].timed_out, 1'b1);
    chk("t5_done", u[0].done, 1'b1);
    chk("t5_run_idx", u[0].run_idx, 8'd0);

    // Restart clears timed_out; reset asserted mid-WAIT clears everything.
    pulse_start(0, 8'd1, {32'd0, 32'd0});
    chk("t6_timed_out_cleared", u[0].timed_out, 1'b0);
    tick();
    tick();
    chk("t6_busy_in_wait", u[0].busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_busy", u[0].busy, 1'b0);
    chk("t6_async_done", u[0].done, 1'b0);
    chk("t6_async_sum1", u[1].result_sum, 32'd0);
    chk("t6_async_done1", u[1].done, 1'b0);
    chk("t6_async_run_idx1", u[1].run_idx, 8'd0);
    @(negedge clock);
    rst_n = 1'b1;
    res_en[0] = 1'b1;
    tick();
    pulse_start(0, 8'd0, {32'd9, 32'd9});
    chk("t6_zero_runs_done", u[0].done, 1'b1);
    chk("t6_zero_runs_busy", u[0].busy, 1'b0);
    chk("t6_zero_runs_run_idx", u[0].run_idx, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
